// File: rtl/twitch_force_bank_pkg.sv
// Shared types, constants and float helpers for the twitch force bank.
// fmul/fadd: single-precision, round-to-nearest-even, subnormals flush to zero.
package twitch_force_bank_pkg;

  localparam logic [31:0] FP_ZERO      = 32'h0000_0000;
  localparam logic [31:0] FP_ONE       = 32'h3F80_0000;
  localparam logic [31:0] FP_NAN       = 32'h7FC0_0000;
  localparam logic [31:0] SPK_GAIN_DEF = 32'h4480_0000;

  localparam logic [1:0] SEL_B1  = 2'd0;
  localparam logic [1:0] SEL_A1  = 2'd1;
  localparam logic [1:0] SEL_A2  = 2'd2;
  localparam logic [1:0] SEL_RSV = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T3, S_T4, S_WB, S_DONE
  } state_t;

  typedef struct packed {
    logic [31:0] b1;
    logic [31:0] a1;
    logic [31:0] a2;
  } coef_t;

  function automatic logic is_nan(logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // m carries the hidden bit at [23]; g/st are guard and sticky
  function automatic logic [31:0] fp_pack(
    logic s, int e, logic [23:0] m, logic g, logic st);
    logic [24:0] r;
    int ee;
    r  = {1'b0, m} + 25'(g & (st | m[0]));
    ee = e;
    if (r[24]) begin
      r  = r >> 1;
      ee = ee + 1;
    end
    if (ee >= 255) return {s, 8'hFF, 23'd0};
    if (ee <= 0) return {s, 31'd0};
    return {s, ee[7:0], r[22:0]};
  endfunction

  function automatic logic [31:0] fmul(logic [31:0] a, logic [31:0] b);
    logic s;
    logic [47:0] p;
    int e;
    s = a[31] ^ b[31];
    if (is_nan(a)) return a;
    if (is_nan(b)) return b;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return FP_NAN;
      return {s, 8'hFF, 23'd0};
    end
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) return fp_pack(s, e + 1, p[47:24], p[23], |p[22:0]);
    return fp_pack(s, e, p[46:23], p[22], |p[21:0]);
  endfunction

  function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b);
    logic [31:0] x, y;
    logic [27:0] mx, my, sm;
    logic stk;
    int d, e, lz;
    if (is_nan(a)) return a;
    if (is_nan(b)) return b;
    if (a[30:23] == 8'hFF) begin
      if (b[30:23] == 8'hFF && a[31] != b[31]) return FP_NAN;
      return a;
    end
    if (b[30:23] == 8'hFF) return b;
    if (a[30:23] == 8'd0 && b[30:23] == 8'd0) return {a[31] & b[31], 31'd0};
    if (b[30:23] == 8'd0) return a;
    if (a[30:23] == 8'd0) return b;
    if (a[30:0] >= b[30:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    d  = int'(x[30:23]) - int'(y[30:23]);
    mx = {2'b01, x[22:0], 3'b000};
    my = {2'b01, y[22:0], 3'b000};
    if (d > 26) begin
      my = 28'd1;
    end else if (d > 0) begin
      stk = 1'b0;
      for (int i = 0; i < 27; i++)
        if (i < d && my[i]) stk = 1'b1;
      my = (my >> d) | {27'd0, stk};
    end
    sm = (x[31] ^ y[31]) ? mx - my : mx + my;
    if (sm == 28'd0) return FP_ZERO;
    e = int'(x[30:23]);
    if (sm[27]) begin
      sm = {1'b0, sm[27:2], sm[1] | sm[0]};
      e  = e + 1;
    end else begin
      lz = 0;
      for (int i = 0; i < 27; i++)
        if (sm[i]) lz = 26 - i;
      sm = sm << lz;
      e  = e - lz;
    end
    return fp_pack(x[31], e, sm[26:3], sm[2], |sm[1:0]);
  endfunction

endpackage

// File: rtl/twitch_coef_bank.sv
// Per-channel b1/a1/a2 register file, one write port, one read port.
// Ports: clk, reset_n, we/wr_ch/sel/data write, rd_ch -> coef read.
module twitch_coef_bank
  import twitch_force_bank_pkg::*;
#(
  parameter int N_MU = 8,
  parameter int CH_W = $clog2(N_MU)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            we,
  input  logic [CH_W-1:0] wr_ch,
  input  logic [1:0]      sel,
  input  logic [31:0]     data,
  input  logic [CH_W-1:0] rd_ch,
  output coef_t           coef
);

  coef_t bank [N_MU];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_MU; i++) bank[i] <= '0;
    end else if (we && sel != SEL_RSV) begin
      unique case (1'b1)
        (sel == SEL_B1): bank[wr_ch].b1 <= data;
        (sel == SEL_A1): bank[wr_ch].a1 <= data;
        (sel == SEL_A2): bank[wr_ch].a2 <= data;
      endcase
    end
  end

  assign coef = bank[rd_ch];

endmodule

// File: rtl/twitch_force_bank.sv
// N-channel twitch filter sharing one float mult and one add/sub unit.
// Ports: sample_valid/spike_vec in, force_valid/force_sum out, cfg_*, rd_*, err.
module twitch_force_bank
  import twitch_force_bank_pkg::*;
#(
  parameter int          N_MU     = 8,
  parameter int          CH_W     = $clog2(N_MU),
  parameter logic [31:0] SPK_GAIN = SPK_GAIN_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sample_valid,
  input  logic [N_MU-1:0] spike_vec,
  output logic            busy,
  output logic            force_valid,
  output logic [31:0]     force_sum,
  input  logic            cfg_we,
  input  logic [CH_W-1:0] cfg_ch,
  input  logic [1:0]      cfg_sel,
  input  logic [31:0]     cfg_data,
  output logic            cfg_ready,
  input  logic [CH_W-1:0] rd_ch,
  output logic [31:0]     rd_force,
  output logic            err,
  input  logic            clr_err
);

  state_t          state;
  logic [CH_W-1:0] ch;
  logic [N_MU-1:0] spk;
  logic [31:0]     acc, acc_sum;
  logic [31:0]     x1 [N_MU];
  logic [31:0]     y1 [N_MU];
  logic [31:0]     y2 [N_MU];
  logic [31:0]     mul_a, mul_b, prod;
  logic [31:0]     add_a, add_b, sum;
  coef_t           coef;

  twitch_coef_bank #(.N_MU(N_MU), .CH_W(CH_W)) u_coef (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (cfg_we & ~busy),
    .wr_ch   (cfg_ch),
    .sel     (cfg_sel),
    .data    (cfg_data),
    .rd_ch   (ch),
    .coef    (coef)
  );

  always_comb begin
    mul_a = FP_ZERO;
    mul_b = FP_ZERO;
    unique case (state)
      S_T1: begin mul_a = coef.b1; mul_b = x1[ch]; end
      S_T3: begin mul_a = coef.a1; mul_b = y1[ch]; end
      S_T4: begin mul_a = coef.a2; mul_b = y2[ch]; end
      default: ;
    endcase
  end

  assign prod = fmul(mul_a, mul_b);

  // T3/T4 subtract the product; WB reuses the adder for the running sum
  always_comb begin
    add_a = acc;
    add_b = {~prod[31], prod[30:0]};
    if (state == S_WB) begin
      add_a = acc_sum;
      add_b = acc;
    end
  end

  assign sum = fadd(add_a, add_b);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ch          <= '0;
      spk         <= '0;
      acc         <= FP_ZERO;
      acc_sum     <= FP_ZERO;
      busy        <= 1'b0;
      force_valid <= 1'b0;
      force_sum   <= FP_ZERO;
      for (int i = 0; i < N_MU; i++) begin
        x1[i] <= FP_ZERO;
        y1[i] <= FP_ZERO;
        y2[i] <= FP_ZERO;
      end
    end else begin
      unique case (state)
        S_IDLE: if (sample_valid) begin
          spk     <= spike_vec;
          ch      <= '0;
          acc_sum <= FP_ZERO;
          busy    <= 1'b1;
          state   <= S_T1;
        end
        S_T1: begin acc <= prod; state <= S_T3; end
        S_T3: begin acc <= sum;  state <= S_T4; end
        S_T4: begin acc <= sum;  state <= S_WB; end
        S_WB: begin
          y2[ch] <= y1[ch];
          y1[ch] <= acc;
          x1[ch] <= spk[ch] ? SPK_GAIN : FP_ZERO;
          if (ch == CH_W'(N_MU - 1)) begin
            force_sum   <= sum;
            force_valid <= 1'b1;
            state       <= S_DONE;
          end else begin
            acc_sum <= sum;
            ch      <= ch + CH_W'(1);
            state   <= S_T1;
          end
        end
        S_DONE: begin
          force_valid <= 1'b0;
          busy        <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // set wins over clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err <= 1'b0;
    else if (busy && (sample_valid || cfg_we)) err <= 1'b1;
    else if (clr_err) err <= 1'b0;
  end

  assign cfg_ready = ~busy;
  assign rd_force  = y1[rd_ch];

endmodule

// File: tb/tb_twitch_force_bank.sv
// Scoreboarded bench: real-arithmetic reference model vs twitch_force_bank.
// Expected sums are queued at stimulus time and popped on force_valid.
module tb_twitch_force_bank;

  localparam int NM = 8;
  localparam logic [31:0] GAIN = 32'h4480_0000;

  logic        clk = 0;
  logic        reset_n = 0;
  logic        sample_valid = 0;
  logic [7:0]  spike_vec = 0;
  logic        busy, force_valid, cfg_ready, err;
  logic [31:0] force_sum, rd_force;
  logic        cfg_we = 0;
  logic [2:0]  cfg_ch = 0;
  logic [1:0]  cfg_sel = 0;
  logic [31:0] cfg_data = 0;
  logic [2:0]  rd_ch = 0;
  logic        clr_err = 0;

  twitch_force_bank #(.N_MU(NM)) dut (
    .clk(clk), .reset_n(reset_n),
    .sample_valid(sample_valid), .spike_vec(spike_vec),
    .busy(busy), .force_valid(force_valid), .force_sum(force_sum),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .rd_ch(rd_ch), .rd_force(rd_force),
    .err(err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { logic [31:0] sum; int cyc; } sb_t;
  sb_t sb[$];

  logic [31:0] b1m[NM], a1m[NM], a2m[NM];
  logic [31:0] x1m[NM], y1m[NM], y2m[NM];
  logic [31:0] last_sum;

  function automatic real pow2(int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(logic [31:0] v);
    real m;
    if (v[30:23] == 8'd0) return 0.0;
    m = (1.0 + real'(v[22:0]) / 8388608.0) * pow2(int'(v[30:23]) - 127);
    return v[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2f(real r);
    logic s;
    real m, t, rem;
    longint q;
    int e;
    if (r == 0.0) return 32'd0;
    s = r < 0.0;
    m = s ? -r : r;
    e = 127;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    t = m * 8388608.0;
    q = longint'($floor(t));
    rem = t - real'(q);
    if (rem > 0.5 || (rem == 0.5 && q[0])) q++;
    if (q == 64'd16777216) begin q = 64'd8388608; e++; end
    return {s, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] fm(logic [31:0] a, logic [31:0] b);
    return r2f(f2r(a) * f2r(b));
  endfunction

  function automatic logic [31:0] fsub(logic [31:0] a, logic [31:0] b);
    return r2f(f2r(a) - f2r(b));
  endfunction

  function automatic logic [31:0] model_sweep(logic [7:0] v);
    logic [31:0] acc, tot;
    tot = 32'd0;
    for (int c = 0; c < NM; c++) begin
      acc = fm(b1m[c], x1m[c]);
      acc = fsub(acc, fm(a1m[c], y1m[c]));
      acc = fsub(acc, fm(a2m[c], y2m[c]));
      y2m[c] = y1m[c];
      y1m[c] = acc;
      x1m[c] = v[c] ? GAIN : 32'd0;
      tot = r2f(f2r(tot) + f2r(acc));
    end
    return tot;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NM; c++) begin
      b1m[c] = 0; a1m[c] = 0; a2m[c] = 0;
      x1m[c] = 0; y1m[c] = 0; y2m[c] = 0;
    end
    last_sum = 0;
  endfunction

  function automatic void model_cfg(int c, int sel, logic [31:0] d);
    case (sel)
      0: b1m[c] = d;
      1: a1m[c] = d;
      2: a2m[c] = d;
      default: ;
    endcase
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // +0 and -0 are treated as the same force value
  task automatic chk_f(string nm, logic [31:0] act, logic [31:0] exp);
    logic [31:0] a, e;
    a = (act[30:0] == 31'd0) ? 32'd0 : act;
    e = (exp[30:0] == 31'd0) ? 32'd0 : exp;
    chk(nm, a, e);
  endtask

  always @(negedge clk) begin
    if (reset_n && force_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_force_valid: got %08h expected none", force_sum);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk_f("force_sum", force_sum, e.sum);
        chk("latency", 32'(cyc - e.cyc), 32'd33);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    #1;
    sb.delete();
    model_reset();
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic cfg(int c, int sel, logic [31:0] d, bit accept);
    @(negedge clk);
    cfg_we = 1; cfg_ch = 3'(c); cfg_sel = 2'(sel); cfg_data = d;
    if (accept) model_cfg(c, sel, d);
    @(negedge clk);
    cfg_we = 0;
  endtask

  task automatic do_sample(logic [7:0] v);
    sb_t e;
    @(negedge clk);
    sample_valid = 1; spike_vec = v;
    e.cyc = cyc;
    e.sum = model_sweep(v);
    last_sum = e.sum;
    sb.push_back(e);
    @(negedge clk);
    sample_valid = 0;
  endtask

  task automatic sample_with_cfg(logic [7:0] v, int c, int sel, logic [31:0] d);
    sb_t e;
    @(negedge clk);
    sample_valid = 1; spike_vec = v;
    cfg_we = 1; cfg_ch = 3'(c); cfg_sel = 2'(sel); cfg_data = d;
    model_cfg(c, sel, d);
    e.cyc = cyc;
    e.sum = model_sweep(v);
    last_sum = e.sum;
    sb.push_back(e);
    @(negedge clk);
    sample_valid = 0; cfg_we = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (!busy && sb.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL sweep_timeout: got busy=%0d pending=%0d expected idle", busy, sb.size());
    sb.delete();
  endtask

  task automatic chk_rd(string nm, int c, logic [31:0] exp);
    rd_ch = 3'(c);
    #1;
    chk_f(nm, rd_force, exp);
  endtask

  function automatic logic [31:0] rand_coef(real lim);
    real r;
    r = real'($urandom_range(0, 100000)) / 100000.0 * lim;
    if ($urandom_range(0, 1) == 1) r = -r;
    return r2f(r);
  endfunction

  initial begin
    logic [31:0] prev;
    model_reset();
    do_reset();

    chk("rst_busy", 32'(busy), 0);
    chk("rst_force_valid", 32'(force_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_force_sum", force_sum, 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 1);

    cfg(0, 0, 32'h3F80_0000, 1);
    do_sample(8'h01);
    wait_done();
    do_sample(8'h01);
    repeat (15) @(negedge clk);
    reset_n = 0;
    #1;
    sb.delete();
    model_reset();
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_force_sum", force_sum, 0);
    for (int c = 0; c < NM; c++) chk_rd("midrst_rd_force", c, 32'd0);
    @(negedge clk);
    reset_n = 1;
    cfg(0, 0, 32'h3F80_0000, 1);
    do_sample(8'h00);
    wait_done();
    chk_rd("midrst_restart_y0", 0, 32'd0);

    do_reset();
    cfg(0, 0, 32'h3F00_0000, 1);
    do_sample(8'h01); wait_done(); chk_rd("delay_s1", 0, 32'h0000_0000);
    do_sample(8'h00); wait_done(); chk_rd("delay_s2", 0, 32'h4400_0000);
    do_sample(8'h00); wait_done(); chk_rd("delay_s3", 0, 32'h0000_0000);

    do_reset();
    cfg(0, 0, 32'h3F80_0000, 1);
    cfg(0, 1, 32'hBF00_0000, 1);
    do_sample(8'h01); wait_done();
    do_sample(8'h00); wait_done(); chk_rd("decay_s2", 0, 32'h4480_0000);
    do_sample(8'h00); wait_done(); chk_rd("decay_s3", 0, 32'h4400_0000);
    do_sample(8'h00); wait_done(); chk_rd("decay_s4", 0, 32'h4380_0000);

    do_reset();
    for (int c = 0; c < 2; c++) begin
      cfg(c, 0, 32'h3F80_0000, 1);
      cfg(c, 1, 32'hBF00_0000, 1);
    end
    do_sample(8'h03); wait_done();
    do_sample(8'h00); wait_done();
    chk("sum_s2", force_sum, 32'h4500_0000);

    prev = last_sum;
    do_sample(8'h01);
    repeat (9) @(negedge clk);
    sample_valid = 1; spike_vec = 8'hFF;
    @(negedge clk);
    sample_valid = 0;
    #1;
    chk("overrun_err", 32'(err), 1);
    chk("overrun_force_sum", force_sum, prev);
    wait_done();

    @(negedge clk);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    #1;
    chk("clr_err", 32'(err), 0);

    do_sample(8'h01);
    repeat (3) @(negedge clk);
    cfg(0, 0, 32'h4000_0000, 0);
    #1;
    chk("cfg_busy_err", 32'(err), 1);
    wait_done();
    do_sample(8'h00); wait_done();
    do_sample(8'h00); wait_done();

    do_sample(8'h00);
    repeat (3) @(negedge clk);
    clr_err = 1;
    cfg(1, 0, 32'h4000_0000, 0);
    clr_err = 0;
    #1;
    chk("set_wins_err", 32'(err), 1);
    wait_done();
    @(negedge clk);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    #1;
    chk("clr_err2", 32'(err), 0);

    cfg(0, 3, 32'h4100_0000, 1);
    do_sample(8'h01); wait_done();
    do_sample(8'h00); wait_done();
    chk_rd("rsv_sel_y0", 0, y1m[0]);

    do_reset();
    for (int c = 0; c < NM; c++) begin
      cfg(c, 0, rand_coef(2.0), 1);
      cfg(c, 1, rand_coef(0.6), 1);
      cfg(c, 2, rand_coef(0.35), 1);
    end
    for (int n = 0; n < 40; n++) begin
      int r, c;
      r = int'($urandom_range(0, 5));
      c = int'($urandom_range(0, NM - 1));
      if (r == 0) begin
        cfg(c, int'($urandom_range(0, 3)), rand_coef(0.3), 1);
        do_sample(8'($urandom));
      end else if (r == 1) begin
        sample_with_cfg(8'($urandom), c, 0, rand_coef(2.0));
      end else begin
        do_sample(8'($urandom));
      end
      wait_done();
      c = int'($urandom_range(0, NM - 1));
      chk_rd("rand_rd_force", c, y1m[c]);
    end
    chk("rand_err", 32'(err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
